// File: rtl/timer_share_ctrl.sv
// timer_share_ctrl: round-robin owner of one shared interval down-counter.
// Requesters raise req[i] with a duration. The block grants the counter to one
// of them, counts down on tick, then pulses done[i] to that requester.
module timer_share_ctrl #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned CNT_W = 24
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   tick,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*CNT_W-1:0] dur,
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       done,
    output logic                   busy,
    output logic [CNT_W-1:0]       count
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] last;

    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] scan_idx;
    logic [CNT_W-1:0] win_dur;

    // Requester index at a given offset after base, wrapping at N_REQ.
    function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base,
                                                input int unsigned      off);
        int unsigned sum;
        sum = 32'(base) + off;
        return IDX_W'(sum % N_REQ);
    endfunction

    // Round-robin pick: scan far-to-near so the nearest pending requester after last wins.
    always_comb begin
        winner   = last;
        scan_idx = last;
        for (int unsigned k = N_REQ; k >= 1; k--) begin
            scan_idx = rr_idx(last, k);
            if (req[scan_idx]) begin
                winner = scan_idx;
            end
        end
    end

    // Duration of the arbitration winner, sampled only when the grant is taken.
    always_comb begin
        win_dur = dur[32'(winner)*CNT_W +: CNT_W];
    end

    // Scheduler FSM with registered grant/done/busy/count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            owner <= '0;
            last  <= IDX_W'(N_REQ - 1);
            grant <= '0;
            done  <= '0;
            busy  <= 1'b0;
            count <= '0;
        end else begin
            done <= '0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        owner <= winner;
                        last  <= winner;
                        count <= (win_dur == '0) ? CNT_W'(1) : win_dur;
                        grant <= N_REQ'(1) << winner;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (!req[owner]) begin
                        // Abort: release silently, no done pulse.
                        state <= IDLE;
                        count <= '0;
                        grant <= '0;
                        busy  <= 1'b0;
                    end else if (tick) begin
                        if (count == CNT_W'(1)) begin
                            state <= DONE;
                            count <= '0;
                            grant <= '0;
                            done  <= N_REQ'(1) << owner;
                        end else begin
                            count <= count - CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                    count <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_timer_share_ctrl.sv
// Bench for timer_share_ctrl: directed scenarios plus random traffic, all
// checked every cycle against a transaction-level reference model.
module tb_timer_share_ctrl;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned CNT_W = 24;

    logic                   clk;
    logic                   reset;
    logic                   tick;
    logic [N_REQ-1:0]       req;
    logic [N_REQ*CNT_W-1:0] dur;
    logic [N_REQ-1:0]       grant;
    logic [N_REQ-1:0]       done;
    logic                   busy;
    logic [CNT_W-1:0]       count;

    timer_share_ctrl #(.N_REQ(N_REQ), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .tick  (tick),
        .req   (req),
        .dur   (dur),
        .grant (grant),
        .done  (done),
        .busy  (busy),
        .count (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model: who holds the counter, ticks left, who is owed a done pulse.
    int m_owner;
    int m_left;
    int m_done_to;
    int m_last;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, got, exp);
    endtask

    function automatic logic [N_REQ-1:0] onehot(input int i);
        logic [N_REQ-1:0] v;
        v = '0;
        if (i >= 0) v[i] = 1'b1;
        return v;
    endfunction

    function automatic int dur_of(input int i);
        return int'(dur[i*CNT_W +: CNT_W]);
    endfunction

    task automatic set_dur(input int i, input int v);
        dur[i*CNT_W +: CNT_W] = CNT_W'(v);
    endtask

    task automatic model_reset();
        m_owner   = -1;
        m_left    = 0;
        m_done_to = -1;
        m_last    = N_REQ - 1;
    endtask

    // One clock edge of the specified behaviour, using the inputs seen at that edge.
    task automatic model_edge();
        if (m_owner >= 0) begin
            if (!req[m_owner]) begin
                m_owner = -1;
                m_left  = 0;
            end else if (tick) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_done_to = m_owner;
                    m_owner   = -1;
                end
            end
        end else if (m_done_to >= 0) begin
            m_done_to = -1;
        end else if (req != '0) begin
            for (int off = 1; off <= N_REQ; off++) begin
                int c;
                c = (m_last + off) % N_REQ;
                if (req[c] && m_owner < 0) begin
                    m_owner = c;
                    m_last  = c;
                    m_left  = (dur_of(c) == 0) ? 1 : dur_of(c);
                end
            end
        end
    endtask

    task automatic check_outputs();
        check("grant", 32'(grant), 32'(onehot(m_owner)));
        check("done",  32'(done),  32'(onehot(m_done_to)));
        check("busy",  32'(busy),  32'((m_owner >= 0) || (m_done_to >= 0)));
        check("count", 32'(count), 32'(m_left));
    endtask

    // Advance one clock and compare all outputs 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        check_outputs();
    endtask

    // Asynchronous reset pulse between edges; outputs must clear before any edge.
    task automatic do_reset();
        #2 reset = 1'b1;
        model_reset();
        #1;
        check("rst_grant", 32'(grant), 32'(0));
        check("rst_done",  32'(done),  32'(0));
        check("rst_busy",  32'(busy),  32'(0));
        check("rst_count", 32'(count), 32'(0));
        #2 reset = 1'b0;
    endtask

    task automatic go_idle();
        req = '0;
        for (int i = 0; i < 3; i++) step();
    endtask

    initial begin
        int exp_order [5];
        int k;
        int rise_cyc;
        int width;
        int found;
        logic [N_REQ-1:0] prev_g;

        reset = 1'b1;
        tick  = 1'b1;
        req   = '0;
        dur   = '0;
        model_reset();
        #7;
        check_outputs();
        reset = 1'b0;

        // 1: single requester, duration 5
        set_dur(0, 5);
        req = 4'b0001;
        step();
        for (int i = 0; i < 5; i++) begin
            check("t1_count", 32'(count), 32'(5 - i));
            check("t1_grant", 32'(grant), 32'(4'b0001));
            step();
        end
        check("t1_done", 32'(done), 32'(4'b0001));
        req = '0;
        step();
        check("t1_busy_low", 32'(busy), 32'(0));
        go_idle();

        // 2: round-robin with all requesters pending, dur 3
        do_reset();
        for (int i = 0; i < N_REQ; i++) set_dur(i, 3);
        exp_order = '{0, 1, 2, 3, 0};
        k = 0; rise_cyc = 0; width = 0; prev_g = '0;
        req = 4'b1111;
        for (int i = 0; i < 26; i++) begin
            step();
            if (grant != '0 && prev_g == '0) begin
                if (k < 5) check("t2_order", 32'(grant), 32'(onehot(exp_order[k])));
                if (k > 0) check("t2_spacing", 32'(cyc - rise_cyc), 32'(5));
                rise_cyc = cyc;
                k++;
                width = 0;
            end
            if (grant != '0) width++;
            if (grant == '0 && prev_g != '0) check("t2_width", 32'(width), 32'(3));
            prev_g = grant;
        end
        check("t2_grants_seen", 32'(k >= 5), 32'(1));
        go_idle();

        // 3: zero duration behaves as one tick
        set_dur(2, 0);
        req = 4'b0100;
        step();
        check("t3_grant", 32'(grant), 32'(4'b0100));
        step();
        check("t3_done", 32'(done), 32'(4'b0100));
        go_idle();

        // 4: gated tick every third cycle
        set_dur(1, 4);
        req = 4'b0010;
        for (int i = 0; i < 20; i++) begin
            tick = (i % 3 == 2);
            step();
        end
        tick = 1'b1;
        go_idle();

        // 5: abort at count 6, then round-robin continues after requester 0
        do_reset();
        set_dur(0, 10);
        set_dur(1, 2);
        req = 4'b0001;
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            step();
            if (m_owner == 0 && m_left == 6) found = 1;
        end
        check("t5_reach6", 32'(found), 32'(1));
        req = '0;
        step();
        check("t5_abort_grant", 32'(grant), 32'(0));
        check("t5_abort_count", 32'(count), 32'(0));
        req = 4'b0011;
        step();
        check("t5_rr_next", 32'(grant), 32'(4'b0010));
        go_idle();

        // 6: asynchronous reset in the middle of an interval
        set_dur(0, 10);
        req = 4'b0001;
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            step();
            if (m_owner == 0 && m_left == 7) found = 1;
        end
        check("t6_reach7", 32'(found), 32'(1));
        req = 4'b1000;
        set_dur(3, 2);
        do_reset();
        step();
        check("t6_grant", 32'(grant), 32'(4'b1000));
        step();
        step();
        check("t6_done", 32'(done), 32'(4'b1000));
        go_idle();

        // Random traffic: requesters hold req until done or an occasional abort
        for (int c = 0; c < 600; c++) begin
            tick = (c < 300) ? 1'b1 : 1'($urandom_range(0, 1));
            for (int i = 0; i < N_REQ; i++) begin
                if (!req[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        set_dur(i, int'($urandom_range(0, 6)));
                        req[i] = 1'b1;
                    end
                end else if (m_done_to == i) begin
                    if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
                end else if ($urandom_range(0, 39) == 0) begin
                    req[i] = 1'b0;
                end
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
